// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Shared types and width helpers for the cache flush sequencer.
package VX_gpu_pkg;

  // Flush sequencer states, in the order a flush walks through them.
  typedef enum logic [2:0] {
    FS_IDLE,
    FS_DRAIN,
    FS_FLUSH,
    FS_WAIT_MEM,
    FS_DONE
  } flush_state_e;

  // Index width that never collapses to zero bits, so a single set or way
  // still gets a one-bit port.
  function automatic int up_clog2(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

  // Number of sets for a given geometry.
  function automatic int calc_num_sets(input int cache_size, input int line_size,
                                       input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // Widths for the default geometry (4 KiB, 64 B lines, 4 banks, 4 ways).
  localparam int DEF_NUM_SETS = calc_num_sets(4096, 64, 4, 4);
  localparam int DEF_SET_W    = up_clog2(DEF_NUM_SETS);
  localparam int DEF_WAY_W    = up_clog2(4);
  localparam int DEF_CNT_W    = $clog2(64 + 1);

endpackage

// File: rtl/vx_pending_counter.sv
// Outstanding-read counter: adds one per set bit of inc_i, subtracts one per
// set bit of dec_i in the same cycle, and clamps at zero.
module vx_pending_counter #(
  parameter int N      = 4,
  parameter int CNT_W  = 7,
  parameter int THRESH = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] inc_i,
  input  logic [N-1:0] dec_i,
  output logic         zero_o,
  output logic         below_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W:0]   n_inc, n_dec, total;
  logic             underflow;

  // Net the increments and decrements and compute the clamped next count.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves a variable unassigned would infer a latch.
    n_inc = '0;
    n_dec = '0;
    for (int i = 0; i < N; i++) begin
      n_inc = n_inc + (CNT_W+1)'(inc_i[i]);
      n_dec = n_dec + (CNT_W+1)'(dec_i[i]);
    end
    total     = {1'b0, count_q} + n_inc;
    underflow = (total < n_dec);
    count_d   = underflow ? '0 : CNT_W'(total - n_dec);
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign zero_o  = (count_q == '0);
  assign below_o = (count_q <= CNT_W'(THRESH));

  // A response with no matching outstanding read is an upstream protocol bug.
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !underflow);

endmodule

// File: rtl/vx_cache_flush_ctrl.sv
// Flush sequencer in front of a cache: gates core requests, drains reads,
// walks every (set, way) with a flush command, waits for memory idle, then
// returns the requester's tag.
module vx_cache_flush_ctrl
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS    = 4,
  parameter int CACHE_SIZE  = 4096,
  parameter int LINE_SIZE   = 64,
  parameter int NUM_BANKS   = 4,
  parameter int NUM_WAYS    = 4,
  parameter int MAX_PENDING = 64,
  parameter int TAG_WIDTH   = 8,
  localparam int NUM_SETS   = calc_num_sets(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS),
  localparam int SET_W      = up_clog2(NUM_SETS),
  localparam int WAY_W      = up_clog2(NUM_WAYS),
  localparam int CNT_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQS-1:0]  core_req_valid_in,
  input  logic [NUM_REQS-1:0]  core_req_rw_in,
  output logic [NUM_REQS-1:0]  core_req_ready_out,
  output logic [NUM_REQS-1:0]  core_req_valid_out,
  input  logic [NUM_REQS-1:0]  core_req_ready_in,
  input  logic [NUM_REQS-1:0]  core_rsp_fire,
  input  logic                 flush_req_valid,
  input  logic [TAG_WIDTH-1:0] flush_req_tag,
  output logic                 flush_req_ready,
  output logic                 flush_cmd_valid,
  output logic [SET_W-1:0]     flush_cmd_set,
  output logic [WAY_W-1:0]     flush_cmd_way,
  input  logic                 flush_cmd_ready,
  input  logic                 mem_idle,
  output logic                 flush_rsp_valid,
  output logic [TAG_WIDTH-1:0] flush_rsp_tag,
  input  logic                 flush_rsp_ready
);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(NUM_SETS - 1);
  localparam logic [WAY_W-1:0] WAY_LAST = WAY_W'(NUM_WAYS - 1);

  flush_state_e         state_q, state_d;
  logic [SET_W-1:0]     set_q, set_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;

  logic                 pend_zero, pend_below, gate_open;
  logic [NUM_REQS-1:0]  rd_fire;

  // Zero-latency gate: open only when idle and there is room for a full
  // beat of reads on every port.
  assign gate_open          = (state_q == FS_IDLE) && pend_below;
  assign core_req_valid_out = gate_open ? core_req_valid_in : '0;
  assign core_req_ready_out = gate_open ? core_req_ready_in : '0;
  assign rd_fire            = core_req_valid_out & core_req_ready_in & ~core_req_rw_in;

  vx_pending_counter #(
    .N      (NUM_REQS),
    .CNT_W  (CNT_W),
    .THRESH (MAX_PENDING - NUM_REQS)
  ) u_pending (
    .clk     (clk),
    .rst_n   (reset),
    .inc_i   (rd_fire),
    .dec_i   (core_rsp_fire),
    .zero_o  (pend_zero),
    .below_o (pend_below)
  );

  // Next-state and handshake outputs of the flush sequence.
  always_comb begin
    state_d         = state_q;
    set_d           = set_q;
    way_d           = way_q;
    tag_d           = tag_q;
    flush_req_ready = 1'b0;
    flush_cmd_valid = 1'b0;
    flush_rsp_valid = 1'b0;
    case (state_q)
      FS_IDLE: begin
        flush_req_ready = 1'b1;
        if (flush_req_valid) begin
          tag_d   = flush_req_tag;
          state_d = FS_DRAIN;
        end
      end
      FS_DRAIN: begin
        if (pend_zero) begin
          set_d   = '0;
          way_d   = '0;
          state_d = FS_FLUSH;
        end
      end
      FS_FLUSH: begin
        flush_cmd_valid = 1'b1;
        if (flush_cmd_ready) begin
          if (way_q == WAY_LAST) begin
            way_d = '0;
            if (set_q == SET_LAST) begin
              set_d   = '0;
              state_d = FS_WAIT_MEM;
            end else begin
              set_d = set_q + 1'b1;
            end
          end else begin
            way_d = way_q + 1'b1;
          end
        end
      end
      FS_WAIT_MEM: begin
        if (mem_idle) state_d = FS_DONE;
      end
      FS_DONE: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  // Sequencer registers; reset abandons any flush in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FS_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      tag_q   <= tag_d;
    end
  end

  assign flush_cmd_set = set_q;
  assign flush_cmd_way = way_q;
  assign flush_rsp_tag = tag_q;

endmodule

// File: tb/tb_vx_cache_flush_ctrl.sv
// Bench for vx_cache_flush_ctrl: randomized and directed stimulus, a
// transaction-level reference model and a scoreboard-style monitor.
module tb_vx_cache_flush_ctrl;

  localparam int NREQ  = 4;
  localparam int NSETS = 4;
  localparam int NWAYS = 4;
  localparam int MAXP  = 64;
  localparam int NCMD  = NSETS * NWAYS;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] valid_in, rw_in, ready_out, valid_out, ready_in, rsp_fire;
  logic            flush_req_valid, flush_req_ready;
  logic [7:0]      flush_req_tag;
  logic            flush_cmd_valid, flush_cmd_ready;
  logic [1:0]      flush_cmd_set, flush_cmd_way;
  logic            mem_idle;
  logic            flush_rsp_valid, flush_rsp_ready;
  logic [7:0]      flush_rsp_tag;

  always #5 clk = ~clk;

  vx_cache_flush_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .core_req_valid_in  (valid_in),
    .core_req_rw_in     (rw_in),
    .core_req_ready_out (ready_out),
    .core_req_valid_out (valid_out),
    .core_req_ready_in  (ready_in),
    .core_rsp_fire      (rsp_fire),
    .flush_req_valid    (flush_req_valid),
    .flush_req_tag      (flush_req_tag),
    .flush_req_ready    (flush_req_ready),
    .flush_cmd_valid    (flush_cmd_valid),
    .flush_cmd_set      (flush_cmd_set),
    .flush_cmd_way      (flush_cmd_way),
    .flush_cmd_ready    (flush_cmd_ready),
    .mem_idle           (mem_idle),
    .flush_rsp_valid    (flush_rsp_valid),
    .flush_rsp_tag      (flush_rsp_tag),
    .flush_rsp_ready    (flush_rsp_ready)
  );

  typedef struct {int s; int w;} cmd_t;

  cmd_t       exp_cmd[$];
  logic [7:0] exp_tag[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model, state during the current cycle.
  int pend     = 0;
  bit fl_active = 0;
  bit draining  = 0;
  bit cmd_on    = 0;
  int cmd_left  = 0;
  bit waitmem   = 0;
  bit rsp_on    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs against the model each cycle, pops the
  // scoreboard on every handshake, then advances the model.
  always @(negedge clk) begin : mon
    bit   open;
    int   inc, dec, n_pend, n_left;
    bit   n_fl, n_drain, n_cmd, n_wait, n_rsp;
    cmd_t e;
    logic [7:0] et;
    cyc++;
    if (!reset) begin
      check("rst_req_ready", 32'(flush_req_ready), 32'd1);
      check("rst_cmd_valid", 32'(flush_cmd_valid), 32'd0);
      check("rst_rsp_valid", 32'(flush_rsp_valid), 32'd0);
      check("rst_rsp_tag",   32'(flush_rsp_tag),   32'd0);
      check("rst_gate_ready", 32'(ready_out), 32'(ready_in));
      check("rst_gate_valid", 32'(valid_out), 32'(valid_in));
      pend = 0; fl_active = 0; draining = 0; cmd_on = 0; cmd_left = 0;
      waitmem = 0; rsp_on = 0;
      exp_cmd.delete();
      exp_tag.delete();
    end else begin
      open = !fl_active && (pend <= MAXP - NREQ);
      check("gate_valid", 32'(valid_out), open ? 32'(valid_in) : 32'd0);
      check("gate_ready", 32'(ready_out), open ? 32'(ready_in) : 32'd0);
      check("flush_req_ready", 32'(flush_req_ready), 32'(!fl_active));
      check("flush_cmd_valid", 32'(flush_cmd_valid), 32'(cmd_on));
      check("flush_rsp_valid", 32'(flush_rsp_valid), 32'(rsp_on));

      inc    = open ? $countones(valid_in & ready_in & ~rw_in) : 0;
      dec    = $countones(rsp_fire);
      n_pend = pend + inc - dec;
      if (n_pend < 0) n_pend = 0;
      n_fl = fl_active; n_drain = draining; n_cmd = cmd_on; n_left = cmd_left;
      n_wait = waitmem; n_rsp = rsp_on;

      if (!fl_active && flush_req_valid) begin
        n_fl = 1; n_drain = 1;
      end
      if (draining && pend == 0) begin
        n_drain = 0; n_cmd = 1; n_left = NCMD;
      end
      if (cmd_on && flush_cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_extra: got (%0d,%0d) expected none (cycle %0d)",
                   flush_cmd_set, flush_cmd_way, cyc);
        end else begin
          e = exp_cmd.pop_front();
          check("cmd_set", 32'(flush_cmd_set), 32'(e.s));
          check("cmd_way", 32'(flush_cmd_way), 32'(e.w));
        end
        n_left = cmd_left - 1;
        if (n_left == 0) begin
          n_cmd = 0; n_wait = 1;
        end
      end
      if (waitmem && mem_idle) begin
        n_wait = 0; n_rsp = 1;
      end
      if (rsp_on && flush_rsp_ready) begin
        if (exp_tag.size() == 0) begin
          total++; bad++;
          $display("FAIL rsp_extra: got tag 0x%0h expected none (cycle %0d)", flush_rsp_tag, cyc);
        end else begin
          et = exp_tag.pop_front();
          check("rsp_tag", 32'(flush_rsp_tag), 32'(et));
        end
        n_rsp = 0; n_fl = 0;
      end

      pend = n_pend; fl_active = n_fl; draining = n_drain; cmd_on = n_cmd;
      cmd_left = n_left; waitmem = n_wait; rsp_on = n_rsp;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = '0; rw_in = '0; ready_in = '1; rsp_fire = '0;
    flush_req_valid = 1'b0; flush_cmd_ready = 1'b1; mem_idle = 1'b1;
    flush_rsp_ready = 1'b1;
  endtask

  // Raise a flush request; the expected walk and tag enter the scoreboard
  // only when the model says the request will be accepted.
  task automatic issue_flush(input logic [7:0] tag);
    flush_req_valid = 1'b1;
    flush_req_tag   = tag;
    if (!fl_active) begin
      exp_tag.push_back(tag);
      for (int s = 0; s < NSETS; s++)
        for (int w = 0; w < NWAYS; w++)
          exp_cmd.push_back('{s, w});
    end
  endtask

  // Random response mask that never returns more reads than are outstanding.
  function automatic logic [NREQ-1:0] rand_rsp(input int limit, input int pct);
    logic [NREQ-1:0] m;
    m = '0;
    for (int i = 0; i < NREQ; i++)
      if (int'($urandom_range(0, 99)) < pct && $countones(m) < limit) m[i] = 1'b1;
    return m;
  endfunction

  task automatic drain_pending();
    valid_in = '0;
    for (int i = 0; i < 64 && pend > 0; i++) begin
      rsp_fire = rand_rsp(pend, 100);
      step();
    end
    rsp_fire = '0;
  endtask

  task automatic run_flush(input int budget);
    for (int i = 0; i < budget && fl_active; i++) begin
      flush_cmd_ready = ($urandom_range(0, 2) != 0);
      mem_idle        = ($urandom_range(0, 3) == 0);
      flush_rsp_ready = ($urandom_range(0, 1) != 0);
      valid_in        = 4'($urandom);
      rsp_fire        = rand_rsp(pend, 50);
      step();
    end
    idle_inputs();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int wcnt, hold;
    idle_inputs();
    flush_req_tag = '0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Pass-through: four reads, then four responses in one cycle.
    valid_in = '1; step();
    valid_in = '0; rsp_fire = '1; step();
    rsp_fire = '0; step();

    // Outstanding bound: fill to 61, gate must close, one response reopens it.
    repeat (15) begin valid_in = '1; step(); end
    valid_in = 4'b0001; step();
    valid_in = '1; step(); step();
    valid_in = '0; rsp_fire = 4'b0001; step();
    rsp_fire = '0; valid_in = '1; step();
    drain_pending();

    // Drain, walk with toggling cmd_ready, slow mem_idle, delayed rsp_ready.
    valid_in = 4'b0111; rw_in = '0; step();
    valid_in = '0;
    issue_flush(8'h5A); step();
    flush_req_valid = 1'b0;
    wcnt = 0; hold = 0;
    for (int i = 0; i < 200 && fl_active; i++) begin
      flush_cmd_ready = i[0];
      if (i == 4)      rsp_fire = 4'b0001;
      else if (i == 6) rsp_fire = 4'b0010;
      else if (i == 9) rsp_fire = 4'b0100;
      else             rsp_fire = '0;
      if (waitmem) wcnt++;
      mem_idle = (wcnt > 10);
      if (rsp_on) hold++;
      flush_rsp_ready = (hold > 3);
      step();
    end
    idle_inputs();
    step();

    // Minimum-latency flush straight from idle.
    issue_flush(8'h11); step();
    flush_req_valid = 1'b0;
    for (int i = 0; i < 40 && fl_active; i++) step();

    // Randomized traffic with occasional flushes; responses are rarer in the
    // first half so the outstanding bound is reached.
    for (int i = 0; i < 800; i++) begin
      valid_in        = 4'($urandom);
      rw_in           = 4'($urandom);
      ready_in        = 4'($urandom);
      rsp_fire        = rand_rsp(pend, (i < 400) ? 15 : 45);
      flush_cmd_ready = ($urandom_range(0, 3) != 0);
      mem_idle        = ($urandom_range(0, 2) == 0);
      flush_rsp_ready = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 40) == 0) issue_flush(8'($urandom));
      else flush_req_valid = 1'b0;
      step();
    end
    flush_req_valid = 1'b0;
    run_flush(400);
    drain_pending();

    // Reset in the middle of the walk, then a fresh flush from (0,0).
    issue_flush(8'hC3); step();
    flush_req_valid = 1'b0;
    for (int i = 0; i < 100 && !(cmd_on && cmd_left <= 9); i++) step();
    reset = 1'b0; step();
    reset = 1'b1; step();
    issue_flush(8'h3C); step();
    flush_req_valid = 1'b0;
    run_flush(400);
    repeat (3) step();

    check("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
    check("tag_queue_empty", 32'(exp_tag.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_cache_flush_ctrl.md
# vx_cache_flush_ctrl

Flush sequencer placed in front of a cache instance, between the core-side request buses and the cache core bus. On a flush request it blocks new core requests, drains all outstanding reads, walks every (set, way) pair with a flush command broadcast to all banks, waits for the memory side to go idle, then acknowledges with the requester's tag. Outside a flush it is a zero-latency pass-through gate that also enforces a bound on outstanding reads.

## Interface
- NUM_REQS, 4, core request ports
- CACHE_SIZE, 4096, bytes
- LINE_SIZE, 64, bytes
- NUM_BANKS, 4, power of two
- NUM_WAYS, 4, associativity
- MAX_PENDING, 64, outstanding-read bound; must be ≥ NUM_REQS
- TAG_WIDTH, 8, flush request tag
- Derived: NUM_SETS = CACHE_SIZE/(LINE_SIZE·NUM_BANKS·NUM_WAYS); SET_W = UP(CLOG2(NUM_SETS)); WAY_W = UP(CLOG2(NUM_WAYS)); CNT_W = CLOG2(MAX_PENDING+1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- core_req_valid_in  in  NUM_REQS  core request valid
- core_req_rw_in  in  NUM_REQS  1 = write (no response expected)
- core_req_ready_out  out  NUM_REQS  ready to core
- core_req_valid_out  out  NUM_REQS  valid to cache
- core_req_ready_in  in  NUM_REQS  ready from cache
- core_rsp_fire  in  NUM_REQS  read-response handshake observed at cache output
- flush_req_valid  in  1  flush request
- flush_req_tag  in  TAG_WIDTH  requester tag
- flush_req_ready  out  1  flush accepted
- flush_cmd_valid  out  1  per-line flush command to all banks
- flush_cmd_set  out  SET_W  set index
- flush_cmd_way  out  WAY_W  way index
- flush_cmd_ready  in  1  all banks accept
- mem_idle  in  1  cache memory request queues empty, no writeback in flight
- flush_rsp_valid  out  1  flush complete
- flush_rsp_tag  out  TAG_WIDTH  echoed tag
- flush_rsp_ready  in  1  requester accepts completion

## Operation
- States: IDLE, DRAIN, FLUSH, WAIT_MEM, DONE.
- Gate: open only in IDLE and only while pending ≤ MAX_PENDING − NUM_REQS; open ⇒ core_req_valid_out = core_req_valid_in, core_req_ready_out = core_req_ready_in; closed ⇒ both zero.
- Pending counter: next = pending + popcount(valid_out & ready_in & ~rw) − popcount(core_rsp_fire); increment and decrement in the same cycle net out. Decrement at zero is an error (assertion), counter saturates at 0.
- IDLE: flush_req_ready = 1; on flush_req_valid latch tag → DRAIN. Core requests firing in the accept cycle still pass and are counted.
- DRAIN: gate closed; when pending == 0 → FLUSH with set = 0, way = 0.
- FLUSH: flush_cmd_valid = 1; on fire increment way, wrapping to 0 and incrementing set; fire at (NUM_SETS−1, NUM_WAYS−1) → WAIT_MEM.
- WAIT_MEM: when mem_idle → DONE.
- DONE: flush_rsp_valid = 1, flush_rsp_tag = latched tag; on flush_rsp_ready → IDLE. Further flush_req_valid held until IDLE.

## Timing
- Reset (asynchronous assert, synchronous-release semantics at next edge): state IDLE, pending 0, set/way 0, tag 0; flush_req_ready 1, flush_cmd_valid 0, flush_rsp_valid 0, flush_rsp_tag 0; gate open.
- Gate path purely combinational; no added core latency.
- All state transitions registered; minimum flush latency with pending = 0, cmd_ready = 1, mem_idle = 1: accept at cycle 0, DRAIN 1, commands cycles 2…(1 + NUM_SETS·NUM_WAYS), WAIT_MEM next cycle, flush_rsp_valid the cycle after (default parameters: rsp at cycle 19).
- flush_cmd_* and flush_rsp_* stable while valid and not ready.
- Reset mid-flush abandons sequence; no response issued.

## Structure
- VX_gpu_pkg: flush_state_e enum, derived-width constants.
- One sub-module: vx_pending_counter (multi-increment/decrement saturating counter with threshold output).

## Test plan
- Pass-through: 4 reads, rw = 0, cache ready → pending = 4, responses on 4 ports same cycle → pending = 0.
- Bound: pending = 61 (MAX 64, NUM_REQS 4) → all core_req_ready_out = 0; one response → gate reopens next cycle.
- Drain: 3 reads outstanding, flush tag 0x5A → no cmd until third response; first flush_cmd_valid the cycle after pending = 0.
- Walk: cmd_ready toggled every other cycle → 16 commands, order (0,0),(0,1)…(3,3), no repeats or skips.
- Completion: mem_idle held low 10 cycles in WAIT_MEM → flush_rsp_valid rises one cycle after mem_idle; tag = 0x5A; held until rsp_ready.
- Reset at mid-FLUSH → all outputs at reset values; new flush starts from (0,0).
